// File: rtl/rtc_tick_gen.sv
// -----------------------------------------------------------------------------
// rtc_tick_gen
//
// Programmable prescaler that produces a periodic single-cycle tick strobe from
// the system clock. With divisor N, one tick is issued every N clock cycles.
// The divisor can be changed at runtime through a valid/ready handshake.
// While running, a new divisor waits in a one-deep pending slot. It is applied
// only when the current period reloads, so no period is ever shortened.
//
// Optional feature macro: RTC_TICK_GEN_CNT_EN
//   When this macro is defined, a CNT_W-bit running count of issued ticks is
//   added and driven out on tick_cnt_o.
//
// Parameters
//   DIV_W   : divisor width in bits
//   DEF_DIV : divisor loaded at reset (1 .. 2^DIV_W-1)
//   CNT_W   : tick counter width (only used with RTC_TICK_GEN_CNT_EN)
//
// Ports
//   clk_i       : clock, rising edge
//   arst_ni     : synchronous active-low reset
//   en_i        : run enable (level)
//   div_i       : offered divisor (0 is treated as 1)
//   div_valid_i : div_i is offered
//   div_ready_o : a divisor can be accepted (pending slot empty)
//   tick_o      : registered tick strobe
//   busy_o      : high while running
//   tick_cnt_o  : total ticks issued (RTC_TICK_GEN_CNT_EN only)
// -----------------------------------------------------------------------------
module rtc_tick_gen #(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned DEF_DIV = 10,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_valid_i,
  output logic             div_ready_o,
  output logic             tick_o,
  output logic             busy_o
`ifdef RTC_TICK_GEN_CNT_EN
  ,
  output logic [CNT_W-1:0] tick_cnt_o
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEF_DIV);

  // A zero divisor would mean "tick every zero cycles"; treat it as 1 so the
  // stored divisor is always a legal period.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    logic [DIV_W-1:0] r;
    if (d == DIV_ZERO) begin
      r = DIV_ONE;
    end else begin
      r = d;
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [DIV_W-1:0] act_div_q, act_div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_vld_q, pend_vld_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  logic             accept_s;
  logic [DIV_W-1:0] div_clamp_s;
  logic             cnt_zero_s;

  assign accept_s    = div_valid_i & ~pend_vld_q;
  assign div_clamp_s = clamp_div(div_i);
  assign cnt_zero_s  = (cnt_q == DIV_ZERO);

  assign div_ready_o = ~pend_vld_q;
  assign tick_o      = tick_q;
  assign busy_o      = (state_q == ST_RUN);

  // State register.
  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: the enable level alone decides between IDLE and RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (en_i) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: a tick is issued on every reload edge while running.
  always_comb begin
    tick_d = 1'b0;
    case (state_q)
      ST_IDLE: tick_d = 1'b0;
      ST_RUN: begin
        if (en_i && cnt_zero_s) begin
          tick_d = 1'b1;
        end else begin
          tick_d = 1'b0;
        end
      end
      default: tick_d = 1'b0;
    endcase
  end

  // Datapath next-state: divisor slots and the period down-counter.
  always_comb begin
    act_div_d  = act_div_q;
    pend_div_d = pend_div_q;
    pend_vld_d = pend_vld_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        // No period is running, so any new divisor becomes active at once.
        // A divisor left pending by a disable is promoted here as well.
        // accept_s and pend_vld_q are mutually exclusive.
        if (accept_s) begin
          act_div_d = div_clamp_s;
        end else if (pend_vld_q) begin
          act_div_d  = pend_div_q;
          pend_vld_d = 1'b0;
        end else begin
          act_div_d = act_div_q;
        end
        // Starting: load N-1 so the first tick follows N edges after start.
        if (en_i) begin
          cnt_d = act_div_d - DIV_ONE;
        end else begin
          cnt_d = DIV_ZERO;
        end
      end
      ST_RUN: begin
        if (en_i) begin
          if (cnt_zero_s) begin
            // Period boundary: the pending divisor, if any, takes over here.
            if (pend_vld_q) begin
              cnt_d      = pend_div_q - DIV_ONE;
              act_div_d  = pend_div_q;
              pend_vld_d = 1'b0;
            end else begin
              cnt_d = act_div_q - DIV_ONE;
            end
          end else begin
            cnt_d = cnt_q - DIV_ONE;
          end
        end else begin
          // Disable discards the partial period.
          cnt_d = DIV_ZERO;
        end
        // Accepted only when the slot is empty, so this never overwrites a
        // divisor consumed on the same edge; it waits for the next reload.
        if (accept_s) begin
          pend_div_d = div_clamp_s;
          pend_vld_d = 1'b1;
        end else begin
          pend_div_d = pend_div_q;
        end
      end
      default: begin
        act_div_d  = DIV_RST;
        pend_div_d = DIV_ZERO;
        pend_vld_d = 1'b0;
        cnt_d      = DIV_ZERO;
      end
    endcase
  end

  // Datapath and tick output registers.
  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      act_div_q  <= DIV_RST;
      pend_div_q <= DIV_ZERO;
      pend_vld_q <= 1'b0;
      cnt_q      <= DIV_ZERO;
      tick_q     <= 1'b0;
    end else begin
      act_div_q  <= act_div_d;
      pend_div_q <= pend_div_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
    end
  end

`ifdef RTC_TICK_GEN_CNT_EN
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;

  assign tick_cnt_o = tick_cnt_q;

  // Tick counter next-state: counts issued ticks, wraps naturally, holds
  // in IDLE because no tick is issued there.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (tick_d) begin
      tick_cnt_d = tick_cnt_q + CNT_W'(1);
    end else begin
      tick_cnt_d = tick_cnt_q;
    end
  end

  // Tick counter register; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      tick_cnt_q <= {CNT_W{1'b0}};
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end
`endif

endmodule

// File: doc/rtc_tick_gen.md
# rtc_tick_gen

Programmable prescaler that derives a periodic single-cycle real-time tick strobe from the system clock. It is the producer of the `rtc_i` tick stream consumed by tick-counting blocks such as delay generators and timeouts. The divisor is runtime-updatable through a valid/ready handshake, and updates are applied only on period boundaries so no tick period is ever truncated.

## Interface

Parameters:
- `DIV_W`, 16: divisor width in bits.
- `DEF_DIV`, 10: divisor loaded at reset. Must be in the range 1..2^DIV_W-1.
- `CNT_W`, 32: width of the tick counter. Used only when the counter is compiled in (see Configuration).

Ports:
- `clk_i`, input, 1: clock; all logic is on the rising edge.
- `arst_ni`, input, 1: reset; synchronous, active-low.
- `en_i`, input, 1: run enable; level-sensitive.
- `div_i`, input, DIV_W: new divisor N; one tick every N clock cycles.
- `div_valid_i`, input, 1: `div_i` is offered.
- `div_ready_o`, output, 1: a divisor can be accepted.
- `tick_o`, output, 1: registered tick strobe.
- `busy_o`, output, 1: high while in RUN.
- `tick_cnt_o`, output, CNT_W: total ticks issued. Present only with `RTC_TICK_GEN_CNT_EN`.

## Operation

- Registers:
  - `act_div`: active divisor.
  - `pend_div` and `pend_vld`: one-deep pending divisor slot.
  - `cnt`: DIV_W-bit down-counter.
  - `state`: IDLE or RUN.
- Divisor clamp: a value of 0 on `div_i` is clamped to 1 at acceptance, so the stored divisor is always at least 1.
- Handshake:
  - A transfer occurs on any edge where `div_valid_i` and `div_ready_o` are both high.
  - `div_ready_o = !pend_vld`.
  - `div_valid_i` is ignored while `div_ready_o` is low. The source holds the value until accepted.
- IDLE state:
  - `cnt = 0`, `tick_o = 0`.
  - An accepted divisor goes directly into `act_div`; `pend_vld` stays 0.
  - When `en_i` is sampled high, go to RUN and load `cnt = div_eff - 1`.
  - `div_eff` is the divisor accepted on that same edge, if any; otherwise it is `act_div`.
- RUN state:
  - While `en_i` stays high:
    - If `cnt == 0`: set `tick_o <= 1` and reload `cnt`. If `pend_vld` is set, reload from `pend_div`, copy it into `act_div` and clear `pend_vld`; otherwise reload from `act_div`.
    - Otherwise: decrement `cnt` and set `tick_o <= 0`.
  - An accepted divisor goes into the pending slot.
  - A divisor accepted on a reload edge is not used by that reload. It takes effect at the next reload.
- Disable:
  - If `en_i` is sampled low in RUN, go to IDLE with `tick_o <= 0` and `cnt <= 0`. The partial period is discarded and no tick is issued.
  - A pending divisor moves to `act_div` on the following IDLE edge.
- Reset:
  - `state = IDLE`, `act_div = DEF_DIV`, `pend_vld = 0`, `cnt = 0`.
  - Output reset values: `tick_o = 0`, `busy_o = 0`, `div_ready_o = 1`, `tick_cnt_o = 0`.
  - Reset asserted mid-period aborts the period on that edge with no tick.

## Timing

- Number edges from 0, where edge 0 is the first edge at which `en_i` is sampled high in IDLE.
- `busy_o` is high from edge 0 onward, in the same cycle `state` becomes RUN.
- With effective divisor N, `tick_o` is high for exactly one cycle after edges N, 2N, 3N, and so on.
- Ticks are exactly N cycles apart, with no cumulative drift.
- N = 1: `tick_o` is high continuously from edge 1 onward.
- Divisor change from N1 to N2 accepted mid-period:
  - The current period completes at N1.
  - The next tick follows N2 cycles after that reload.
- `en_i` low for a single cycle restarts the phase: the first tick after re-enable arrives N edges after re-entry.
- `div_ready_o` falls on the edge after an accept in RUN. It rises on the edge after the pending slot is consumed.

## Configuration

- `RTC_TICK_GEN_CNT_EN`, when defined:
  - Instantiates the CNT_W-bit `tick_cnt_o` register and port.
  - The register increments on every edge that sets `tick_o <= 1`.
  - It wraps from 2^CNT_W-1 to 0.
  - It holds its value in IDLE.
  - It is cleared only by reset.
- When undefined: the port and register are absent. All other behaviour is identical.

## Test plan

- Reset, DEF_DIV=10, `en_i` high at edge 0 → `tick_o` high only after edges 10, 20 and 30; `busy_o` high from edge 0; `div_ready_o` = 1.
- Accept `div_i`=4 at edge 13 → next tick at edge 20, then at 24 and 28. `div_ready_o` is low from edge 14 through edge 20 and high again after edge 21.
- `div_i`=0 accepted in IDLE, then enable → `tick_o` is high every cycle after edge 1, because the divisor is clamped to 1.
- Drop `en_i` at edge 7 with divisor 10, re-enable at edge 9 → no tick at edge 10; next tick at edge 19; `busy_o` low for the idle cycles.
- Reset asserted at edge 5 mid-period, then re-enable → all outputs return to reset values, the divisor returns to 10, and no stray tick appears.
- With `RTC_TICK_GEN_CNT_EN` defined and CNT_W=4, divisor 1, 17 ticks → `tick_cnt_o` wraps and reads 1; it holds its value after `en_i` falls.
